// File: rtl/fetch_queue.sv
// fetch_queue: PC generator plus prefetch FIFO for the pipelined core.
// Requests are issued in order under a credit limit (FIFO occupancy plus
// in-flight requests never exceeds DEPTH). Returned words are paired with
// their request address from a parallel tag queue. After a jump, responses
// still in flight are counted down and discarded.
module fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h00000013)
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     req_o,
    output logic [ADDR_W-1:0]        req_addr_o,
    input  logic                     rsp_valid_i,
    input  logic [INST_W-1:0]        rsp_inst_i,
    input  logic                     jump_i,
    input  logic [ADDR_W-1:0]        jump_addr_i,
    input  logic                     hold_i,
    output logic                     valid_o,
    output logic [INST_W-1:0]        inst_o,
    output logic [ADDR_W-1:0]        inst_addr_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int                PW      = $clog2(DEPTH);
    localparam int                CW      = PW + 1;
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INST_W / 8);
    localparam logic [CW:0]       DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0]     PTR_ONE = PW'(1);
    localparam logic [CW-1:0]     CNT_ONE = CW'(1);

    logic [ADDR_W-1:0] pc_q;
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [ADDR_W-1:0] tag_mem  [DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [PW-1:0]     tag_wr_q;
    logic [PW-1:0]     tag_rd_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     out_q;
    logic [CW-1:0]     drop_q;

    logic [CW:0]       credit_used;
    logic              req;
    logic              rsp_fire;
    logic              push;
    logic              pop;

    // A response with nothing outstanding is a bus protocol error and is
    // ignored entirely, so it must not touch any counter or pointer.
    assign credit_used = {1'b0, count_q} + {1'b0, out_q};
    assign req         = !rst && !jump_i && (credit_used < DEPTH_C);
    assign rsp_fire    = rsp_valid_i && (out_q != '0);
    assign push        = rsp_fire && (drop_q == '0) && !jump_i;
    assign valid_o     = (count_q != '0);
    assign pop         = valid_o && !hold_i && !jump_i;

    assign req_o       = req;
    assign req_addr_o  = pc_q;
    assign count_o     = count_q;
    assign inst_o      = valid_o ? inst_mem[rd_ptr_q] : NOP_INST;
    assign inst_addr_o = valid_o ? addr_mem[rd_ptr_q] : '0;

    // Control state: PC, FIFO/tag pointers, occupancy and in-flight/drop credit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            tag_wr_q <= '0;
            tag_rd_q <= '0;
            count_q  <= '0;
            out_q    <= '0;
            drop_q   <= '0;
        end else begin
            // Every accepted response retires one tag, dropped or not, so the
            // tag queue stays aligned with the bus across redirects.
            if (rsp_fire) begin
                tag_rd_q <= tag_rd_q + PTR_ONE;
            end
            if (jump_i) begin
                pc_q     <= jump_addr_i;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                // Everything still in flight after this edge is stale.
                out_q    <= out_q - CW'(rsp_fire);
                drop_q   <= out_q - CW'(rsp_fire);
            end else begin
                if (req) begin
                    pc_q     <= pc_q + PC_STEP;
                    tag_wr_q <= tag_wr_q + PTR_ONE;
                end
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_ONE;
                end
                count_q <= count_q + CW'(push) - CW'(pop);
                out_q   <= out_q + CW'(req) - CW'(rsp_fire);
                if (rsp_fire && (drop_q != '0)) begin
                    drop_q <= drop_q - CNT_ONE;
                end
            end
        end
    end

    // Storage: request tags and FIFO payload; no reset needed for data.
    always_ff @(posedge clk) begin
        if (req) begin
            tag_mem[tag_wr_q] <= pc_q;
        end
        if (push) begin
            inst_mem[wr_ptr_q] <= rsp_inst_i;
            addr_mem[wr_ptr_q] <= tag_mem[tag_rd_q];
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized bench for fetch_queue with a queue-based
// reference model and a scoreboard of instructions handed to decode.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] NOP      = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_o;
    logic [31:0] req_addr_o;
    logic        rsp_valid_i = 1'b0;
    logic [31:0] rsp_inst_i = '0;
    logic        jump_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        hold_i = 1'b0;
    logic        valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic [2:0]  count_o;

    fetch_queue #(
        .ADDR_W(32), .INST_W(32), .DEPTH(DEPTH),
        .RESET_PC(RESET_PC), .NOP_INST(NOP)
    ) dut (
        .clk(clk), .rst(rst),
        .req_o(req_o), .req_addr_o(req_addr_o),
        .rsp_valid_i(rsp_valid_i), .rsp_inst_i(rsp_inst_i),
        .jump_i(jump_i), .jump_addr_i(jump_addr_i),
        .hold_i(hold_i),
        .valid_o(valid_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
        .count_o(count_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; bit stale; int rdy; } fl_t;
    typedef struct { logic [31:0] addr; logic [31:0] inst; } ent_t;
    typedef struct { bit req; logic [31:0] addr; int cnt; bit vld; } cyc_t;

    fl_t  inflight[$];   // requests on the bus, oldest first
    ent_t mfifo[$];      // model prefetch buffer contents
    ent_t sb[$];         // instructions expected to be consumed by decode
    cyc_t exp_cyc[$];    // per-cycle expected request/occupancy view

    logic [31:0] mpc;
    int cyc = 0;
    int lat_max = 0;
    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    // One cycle of stimulus: pick inputs, record expectations, advance the model.
    // rmode: 0 = no response, 1 = random response, 2 = respond whenever ready.
    task automatic step(input bit h, input bit j, input logic [31:0] ja, input int rmode);
        bit          r_real;
        bit          r_stray;
        logic [31:0] ri;
        cyc_t        e;
        fl_t         f;
        r_real  = 1'b0;
        r_stray = 1'b0;
        ri      = '0;
        if (inflight.size() > 0 && inflight[0].rdy <= cyc &&
            (rmode == 2 || (rmode == 1 && $urandom_range(99) < 60))) begin
            r_real = 1'b1;
            ri     = inst_of(inflight[0].addr);
        end else if (inflight.size() == 0 && rmode == 1 && $urandom_range(99) < 5) begin
            r_stray = 1'b1;
            ri      = $urandom;
        end
        hold_i      = h;
        jump_i      = j;
        jump_addr_i = ja;
        rsp_valid_i = r_real || r_stray;
        rsp_inst_i  = ri;

        e.req  = !j && ((mfifo.size() + inflight.size()) < DEPTH);
        e.addr = mpc;
        e.cnt  = mfifo.size();
        e.vld  = (mfifo.size() > 0);
        exp_cyc.push_back(e);

        if (j) begin
            mfifo.delete();
            if (r_real) void'(inflight.pop_front());
            foreach (inflight[k]) inflight[k].stale = 1'b1;
            mpc = ja;
        end else begin
            if (e.vld && !h) begin
                sb.push_back(mfifo[0]);
                void'(mfifo.pop_front());
            end
            if (r_real) begin
                f = inflight.pop_front();
                if (!f.stale) mfifo.push_back('{f.addr, ri});
            end
            if (e.req) begin
                inflight.push_back('{mpc, 1'b0, cyc + 1 + $urandom_range(lat_max)});
                mpc = mpc + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic tick(input bit h, input bit j, input logic [31:0] ja, input int rmode);
        @(posedge clk);
        #1;
        step(h, j, ja, rmode);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " req_o"}, req_o, 0);
        chk({tag, " req_addr_o"}, req_addr_o, RESET_PC);
        chk({tag, " valid_o"}, valid_o, 0);
        chk({tag, " inst_o"}, inst_o, NOP);
        chk({tag, " inst_addr_o"}, inst_addr_o, 0);
        chk({tag, " count_o"}, count_o, 0);
    endtask

    // Assert reset mid-cycle, check outputs before any edge, then release
    // and immediately model the first post-reset cycle.
    task automatic do_reset();
        @(posedge clk);
        #1;
        hold_i = 1'b0; jump_i = 1'b0; rsp_valid_i = 1'b0;
        #1 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        @(posedge clk);
        #1 check_reset_outputs("held_rst");
        mfifo.delete();
        inflight.delete();
        mpc = RESET_PC;
        rst = 1'b0;
        step(1'b0, 1'b0, 32'h0, 0);
    endtask

    // Monitor: compare every cycle's outputs and each consumed instruction.
    initial begin
        cyc_t e;
        ent_t s;
        forever begin
            @(negedge clk);
            if (!rst && exp_cyc.size() > 0) begin
                e = exp_cyc.pop_front();
                chk("req_o", req_o, e.req);
                if (e.req) chk("req_addr_o", req_addr_o, e.addr);
                chk("count_o", count_o, e.cnt);
                chk("valid_o", valid_o, e.vld);
                if (!valid_o) begin
                    chk("inst_o_idle", inst_o, NOP);
                    chk("inst_addr_o_idle", inst_addr_o, 0);
                end
                if (valid_o && !hold_i && !jump_i) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_pop", 1, 0);
                    end else begin
                        s = sb.pop_front();
                        chk("inst_addr_o", inst_addr_o, s.addr);
                        chk("inst_o", inst_o, s.inst);
                    end
                end
            end
        end
    end

    initial begin
        mpc = RESET_PC;
        repeat (2) @(posedge clk);
        do_reset();

        // Streaming, single-cycle response latency.
        lat_max = 0;
        repeat (20) tick(1'b0, 1'b0, 32'h0, 2);

        // Decode stall with responses flowing, then release.
        repeat (10) tick(1'b1, 1'b0, 32'h0, 2);
        repeat (10) tick(1'b0, 1'b0, 32'h0, 2);

        // Build up 3 queued + 1 outstanding, then reset mid-operation.
        repeat (8) tick(1'b1, 1'b0, 32'h0, (mfifo.size() < 3) ? 2 : 0);
        do_reset();

        // Jump to 0x100 with requests outstanding.
        lat_max = 2;
        repeat (2) tick(1'b0, 1'b0, 32'h0, 0);
        tick(1'b0, 1'b1, 32'h100, 0);
        repeat (20) tick(1'b0, 1'b0, 32'h0, 2);

        // Jump together with a response and a pop, then a second jump.
        lat_max = 0;
        repeat (3) tick(1'b1, 1'b0, 32'h0, 2);
        tick(1'b0, 1'b1, 32'h200, 2);
        tick(1'b0, 1'b0, 32'h0, 0);
        tick(1'b1, 1'b1, 32'h300, 1);
        repeat (20) tick(1'b0, 1'b0, 32'h0, 2);

        // PC wrap at the top of the address space.
        tick(1'b0, 1'b1, 32'hFFFF_FFF8, 0);
        repeat (20) tick(1'b0, 1'b0, 32'h0, 2);

        // Random traffic: holds, jumps, variable latency, stray responses.
        lat_max = 3;
        repeat (800) tick($urandom_range(99) < 30, $urandom_range(99) < 3,
                          $urandom & 32'hFFFF_FFFC, 1);

        // Drain and confirm everything expected was consumed.
        repeat (30) tick(1'b0, 1'b0, 32'h0, 2);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        chk("cycles_checked", exp_cyc.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
